// File: rtl/iter_accum_if.sv
// Handshake/data bundle for iter_accum: start/done framing, sample valid/ready, result and status.
interface iter_accum_if #(
    parameter int W     = 100,
    parameter int CNT_W = 7,
    parameter int SH_W  = 3
) ();
    logic             start;
    logic [CNT_W-1:0] n_iter;
    logic [SH_W-1:0]  shift;
    logic             r_valid;
    logic [W-1:0]     r;
    logic             r_ready;
    logic [W-1:0]     y;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, n_iter, shift, r_valid, r,
        input  r_ready, y, busy, done, ovf
    );

    modport slave (
        input  start, n_iter, shift, r_valid, r,
        output r_ready, y, busy, done, ovf
    );
endinterface

// File: rtl/iter_accum.sv
// Iterative shift-accumulator: y <= (y << shift) + r per accepted sample, n_iter samples per run.
// Define ITER_ACCUM_SAT_EN to saturate y to all ones on an overflowing accept instead of wrapping.
module iter_accum #(
    parameter int W     = 100,
    parameter int CNT_W = 7,
    parameter int SH_W  = 3
) (
    input  logic         clk,
    input  logic         rst,
    iter_accum_if.slave  bus
);
    localparam int EXT  = (1 << SH_W) - 1;
    localparam int WIDE = W + EXT + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [W-1:0]     r_y;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_nIter;
    logic [SH_W-1:0]  r_shift;
    logic             r_ovf;

    logic             w_accept;
    logic             w_startRun;
    logic             w_startEmpty;
    logic             w_ovfNow;
    logic [WIDE-1:0]  w_shifted;
    logic [WIDE-1:0]  w_sum;
    logic [W-1:0]     w_yNext;

    // Exact sum is kept wide enough that any bit above W means overflow (shifted-out bits or carry).
    assign w_shifted = {{(EXT + 1){1'b0}}, r_y} << r_shift;
    assign w_sum     = w_shifted + {{(EXT + 1){1'b0}}, bus.r};
    assign w_ovfNow  = |w_sum[WIDE-1:W];

`ifdef ITER_ACCUM_SAT_EN
    assign w_yNext = w_ovfNow ? {W{1'b1}} : w_sum[W-1:0];
`else
    assign w_yNext = w_sum[W-1:0];
`endif

    assign bus.y   = r_y;
    assign bus.ovf = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        bus.r_ready  = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        w_accept     = 1'b0;
        w_startRun   = 1'b0;
        w_startEmpty = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.n_iter == '0) begin
                        w_startEmpty = 1'b1;
                        w_nextState  = DONE;
                    end else begin
                        w_startRun  = 1'b1;
                        w_nextState = RUN;
                    end
                end
            end
            RUN: begin
                bus.r_ready = 1'b1;
                bus.busy    = 1'b1;
                w_accept    = bus.r_valid;
                if (bus.r_valid && (r_cnt == r_nIter - CNT_W'(1))) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                bus.busy    = 1'b1;
                bus.done    = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_cnt   <= '0;
            r_nIter <= '0;
            r_shift <= '0;
            r_ovf   <= 1'b0;
        end else if (w_startRun) begin
            r_y     <= '0;
            r_cnt   <= '0;
            r_nIter <= bus.n_iter;
            r_shift <= bus.shift;
            r_ovf   <= 1'b0;
        end else if (w_startEmpty) begin
            r_y   <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_y   <= w_yNext;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_ovfNow) begin
                r_ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_iter_accum.sv
// Directed self-checking bench for iter_accum at W=8: vector table plus hand-written corner sequences.
module tb_iter_accum;
    localparam int W     = 8;
    localparam int CNT_W = 7;
    localparam int SH_W  = 3;

    // Expected y after the 200,100 overflow run depends on the saturation build option.
`ifdef ITER_ACCUM_SAT_EN
    localparam logic [W-1:0] OVF_Y = 8'd255;
`else
    localparam logic [W-1:0] OVF_Y = 8'd244;
`endif

    typedef struct {
        string            tag;
        logic             start;
        logic [CNT_W-1:0] nIter;
        logic [SH_W-1:0]  shift;
        logic             rValid;
        logic [W-1:0]     r;
        logic [W-1:0]     expY;
        logic             expReady;
        logic             expBusy;
        logic             expDone;
        logic             expOvf;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    iter_accum_if #(.W(W), .CNT_W(CNT_W), .SH_W(SH_W)) bus ();

    iter_accum #(.W(W), .CNT_W(CNT_W), .SH_W(SH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input string tag, input logic start, input int nIter, input int shift,
                          input logic rValid, input int r, input int expY, input logic expReady,
                          input logic expBusy, input logic expDone, input logic expOvf);
        vec_t v;
        v.tag      = tag;
        v.start    = start;
        v.nIter    = CNT_W'(nIter);
        v.shift    = SH_W'(shift);
        v.rValid   = rValid;
        v.r        = W'(r);
        v.expY     = W'(expY);
        v.expReady = expReady;
        v.expBusy  = expBusy;
        v.expDone  = expDone;
        v.expOvf   = expOvf;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then let the rising edge happen and settle 1 time unit past it.
    task automatic applyStimulus(input logic start, input int nIter, input int shift,
                                 input logic rValid, input int r);
        bus.start   = start;
        bus.n_iter  = CNT_W'(nIter);
        bus.shift   = SH_W'(shift);
        bus.r_valid = rValid;
        bus.r       = W'(r);
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string tag, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int expY, input logic expReady,
                               input logic expBusy, input logic expDone, input logic expOvf);
        checkField(tag, "y", int'(bus.y), expY);
        checkField(tag, "r_ready", int'(bus.r_ready), int'(expReady));
        checkField(tag, "busy", int'(bus.busy), int'(expBusy));
        checkField(tag, "done", int'(bus.done), int'(expDone));
        checkField(tag, "ovf", int'(bus.ovf), int'(expOvf));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.n_iter  = '0;
        bus.shift   = '0;
        bus.r_valid = 1'b0;
        bus.r       = '0;

        // Run A: shift 1, three samples 1,2,3 -> 1, 4, 11
        addVec("a_start", 1, 3, 1, 0, 0,   0, 1, 1, 0, 0);
        addVec("a_r1",    0, 0, 0, 1, 1,   1, 1, 1, 0, 0);
        addVec("a_r2",    0, 0, 0, 1, 2,   4, 1, 1, 0, 0);
        addVec("a_r3",    0, 0, 0, 1, 3,  11, 0, 1, 1, 0);
        addVec("a_idle",  0, 0, 0, 0, 0,  11, 0, 0, 0, 0);
        // Run B: 200 then 100 with shift 1 overflows; ovf sticks into IDLE
        addVec("b_start", 1, 2, 1, 0, 0,   0, 1, 1, 0, 0);
        addVec("b_r1",    0, 0, 0, 1, 200, 200, 1, 1, 0, 0);
        addVec("b_r2",    0, 0, 0, 1, 100, int'(OVF_Y), 0, 1, 1, 1);
        addVec("b_idle",  0, 0, 0, 0, 0,   int'(OVF_Y), 0, 0, 0, 1);
        // Run C: plain accumulation of 5 with bubbles 0,3,1; next start clears ovf
        addVec("c_start", 1, 4, 0, 0, 0,   0, 1, 1, 0, 0);
        addVec("c_r1",    0, 0, 0, 1, 5,   5, 1, 1, 0, 0);
        addVec("c_r2",    0, 0, 0, 1, 5,  10, 1, 1, 0, 0);
        addVec("c_gap1",  0, 0, 0, 0, 9,  10, 1, 1, 0, 0);
        addVec("c_gap2",  0, 0, 0, 0, 9,  10, 1, 1, 0, 0);
        addVec("c_gap3",  0, 0, 0, 0, 9,  10, 1, 1, 0, 0);
        addVec("c_r3",    0, 0, 0, 1, 5,  15, 1, 1, 0, 0);
        addVec("c_gap4",  0, 0, 0, 0, 9,  15, 1, 1, 0, 0);
        addVec("c_r4",    0, 0, 0, 1, 5,  20, 0, 1, 1, 0);
        addVec("c_idle",  0, 0, 0, 0, 0,  20, 0, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].start, int'(vecs[i].nIter), int'(vecs[i].shift),
                          vecs[i].rValid, int'(vecs[i].r));
            checkOutput(vecs[i].tag, int'(vecs[i].expY), vecs[i].expReady, vecs[i].expBusy,
                        vecs[i].expDone, vecs[i].expOvf);
        end

        // Zero-length run: straight to DONE with y cleared, r_ready never high
        applyStimulus(1, 0, 2, 1, 33);
        checkOutput("empty_done", 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 33);
        checkOutput("empty_idle", 0, 0, 0, 0, 0);

        // Reset mid-run aborts without a done pulse, then a fresh short run works
        applyStimulus(1, 5, 2, 0, 0);
        checkOutput("rst_start", 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("rst_r1", 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 2);
        checkOutput("rst_r2", 6, 1, 1, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 1, 3);
        checkOutput("rst_abort", 0, 0, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 3);
        checkOutput("rst_quiet1", 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_quiet2", 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("new_start", 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 7);
        checkOutput("new_r1", 7, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("new_idle", 7, 0, 0, 0, 0);

        // start during RUN and DONE is ignored; latched n_iter=2, shift=1 must be kept
        applyStimulus(1, 2, 1, 0, 0);
        checkOutput("ign_start", 0, 1, 1, 0, 0);
        applyStimulus(1, 5, 0, 1, 3);
        checkOutput("ign_r1", 3, 1, 1, 0, 0);
        applyStimulus(1, 5, 0, 1, 1);
        checkOutput("ign_r2", 7, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 1, 9);
        checkOutput("ign_done", 7, 0, 0, 0, 0);
        applyStimulus(1, 1, 3, 0, 0);
        checkOutput("next_start", 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 2);
        checkOutput("next_r1", 2, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("next_idle", 2, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
